// File: rtl/delay_pkg.sv
// rtl/delay_pkg.sv - shared sizing helpers for the delay line family
package delay_pkg;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of a select able to address taps 0..max_delay, never narrower than one bit.
    function automatic int sel_width(input int max_delay);
        int w;
        w = clog2(max_delay + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Bit offset of a lane inside a lane-packed bus.
    function automatic int lane_lsb(input int lane, input int lane_width);
        return lane * lane_width;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// rtl/delay_stage.sv - one valid/data register of the delay chain
module delay_stage #(
    parameter int WIDTH      = 32,
    parameter int CLEAR_DATA = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_n,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    // Valid bit: flush wins over advance; a stall holds the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else if (!en_n) begin
            valid_out <= valid_in;
        end
    end

    // Data word: only zeroed by flush when clearing is enabled, otherwise it follows en_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (flush && (CLEAR_DATA != 0)) begin
            data_out <= '0;
        end else if (!en_n) begin
            data_out <= data_in;
        end
    end

endmodule

// File: rtl/delay_pipe.sv
// rtl/delay_pipe.sv - multi-lane valid-tracked delay line with runtime tap select
module delay_pipe
    import delay_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int DEPTH      = 1,
    parameter int MAX_DELAY  = 4,
    parameter int CLEAR_DATA = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en_n,
    input  logic                                 flush,
    input  logic [sel_width(MAX_DELAY)-1:0]      delaySel,
    input  logic                                 validIn,
    input  logic [BIT_WIDTH*DEPTH-1:0]           dataIn,
    output logic                                 validOut,
    output logic [BIT_WIDTH*DEPTH-1:0]           dataOut,
    output logic [sel_width(MAX_DELAY)-1:0]      inFlight
);

    localparam int SELW = sel_width(MAX_DELAY);
    localparam int DW   = BIT_WIDTH * DEPTH;

    // Tap 0 is the live input; taps 1..MAX_DELAY are the stage registers.
    logic          stage_v [0:MAX_DELAY];
    logic [DW-1:0] stage_d [0:MAX_DELAY];

    logic [DEPTH-1:0][BIT_WIDTH-1:0] lanes_in;
    logic [DEPTH-1:0][BIT_WIDTH-1:0] lanes_out;

    logic [SELW-1:0] sel;
    logic            tap_v;
    logic [DW-1:0]   tap_d;
    logic [SELW-1:0] count_q;

    // Lane unpack/pack: lane k sits at [k*BIT_WIDTH +: BIT_WIDTH] on both buses.
    for (genvar k = 0; k < DEPTH; k++) begin : g_lane
        assign lanes_in[k] = dataIn[lane_lsb(k, BIT_WIDTH) +: BIT_WIDTH];
        assign dataOut[lane_lsb(k, BIT_WIDTH) +: BIT_WIDTH] = lanes_out[k];
    end

    assign stage_v[0] = validIn;
    assign stage_d[0] = lanes_in;

    for (genvar s = 1; s <= MAX_DELAY; s++) begin : g_stage
        delay_stage #(
            .WIDTH      (DW),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_n      (en_n),
            .flush     (flush),
            .valid_in  (stage_v[s-1]),
            .data_in   (stage_d[s-1]),
            .valid_out (stage_v[s]),
            .data_out  (stage_d[s])
        );
    end

    // Clamp out-of-range selects to the deepest physical stage.
    always_comb begin
        sel = delaySel;
        if (delaySel > SELW'(MAX_DELAY)) begin
            sel = SELW'(MAX_DELAY);
        end
    end

    // Tap mux; select 0 is a purely combinational bypass of the input.
    always_comb begin
        tap_v = stage_v[0];
        tap_d = stage_d[0];
        for (int s = 1; s <= MAX_DELAY; s++) begin
            if (sel == SELW'(s)) begin
                tap_v = stage_v[s];
                tap_d = stage_d[s];
            end
        end
    end

    assign validOut  = tap_v;
    assign lanes_out = tap_d;

    // In-flight count tracks the valid bits of stages 1..MAX_DELAY incrementally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else if (!en_n) begin
            count_q <= count_q + SELW'(validIn) - SELW'(stage_v[MAX_DELAY]);
        end
    end

    assign inFlight = count_q;

endmodule
